// File: rtl/path_pkg.sv
// Shared definitions for the maze path pipeline: direction codes and walker FSM states.
package path_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_DOWN  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOAD   = 2'b01,
    WALK   = 2'b10,
    FINISH = 2'b11
  } walk_state_e;

endpackage

// File: rtl/visit_map.sv
// One bit per grid cell, addressed {y,x}; single-cycle clear that leaves the start cell marked.
module visit_map #(
  parameter int COORD_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic [2*COORD_W-1:0] clear_addr,
  input  logic                 mark,
  input  logic [2*COORD_W-1:0] mark_addr,
  input  logic [2*COORD_W-1:0] test_addr,
  output logic                 visited
);

  localparam int CELLS = 2 ** (2 * COORD_W);

  logic [CELLS-1:0] map_q;
  logic [CELLS-1:0] map_d;

  always_comb begin
    map_d = map_q;
    if (clear) begin
      map_d             = '0;
      map_d[clear_addr] = 1'b1;
    end else if (mark) begin
      map_d[mark_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      map_q <= '0;
    end else begin
      map_q <= map_d;
    end
  end

  assign visited = map_q[test_addr];

endmodule

// File: rtl/path_walker.sv
// Replays a 2-bit direction stream over the maze grid, tracking position, steps and errors.
// Optional revisit detection is enabled by defining REVISIT_CHECK_EN.
module path_walker
  import path_pkg::*;
#(
  parameter int COORD_W = 4,
  parameter int START_X = 0,
  parameter int START_Y = 0,
  parameter int GOAL_X  = 15,
  parameter int GOAL_Y  = 15,
  parameter int STEP_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               dir_valid,
  input  logic [1:0]         dir_in,
  input  logic               stream_done,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic [STEP_W-1:0]  step_count,
  output logic               move_valid,
  output logic               busy,
  output logic               done,
  output logic               at_goal,
  output logic               error
);

  localparam logic [COORD_W-1:0] SX      = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] SY      = COORD_W'(START_Y);
  localparam logic [COORD_W-1:0] GX      = COORD_W'(GOAL_X);
  localparam logic [COORD_W-1:0] GY      = COORD_W'(GOAL_Y);
  localparam logic [COORD_W-1:0] C_ONE   = COORD_W'(1);
  localparam logic [COORD_W-1:0] C_MAX   = '1;
  localparam logic [STEP_W-1:0]  S_ONE   = STEP_W'(1);
  localparam logic [STEP_W-1:0]  S_MAX   = '1;

  walk_state_e        state_q, state_d;
  logic [COORD_W-1:0] pos_x_q, pos_x_d;
  logic [COORD_W-1:0] pos_y_q, pos_y_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic               move_valid_q, move_valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               at_goal_q, at_goal_d;
  logic               error_q, error_d;

  logic [COORD_W-1:0] next_x;
  logic [COORD_W-1:0] next_y;
  logic               out_of_bounds;
  logic               revisit;
  logic               try_move;
  logic               accept;
  logic               reject;

  // Candidate cell for this cycle's direction; an edge move is flagged rather than wrapped.
  always_comb begin
    next_x        = pos_x_q;
    next_y        = pos_y_q;
    out_of_bounds = 1'b0;
    case (dir_in)
      DIR_UP: begin
        if (pos_y_q == '0) out_of_bounds = 1'b1;
        else               next_y = pos_y_q - C_ONE;
      end
      DIR_RIGHT: begin
        if (pos_x_q == C_MAX) out_of_bounds = 1'b1;
        else                  next_x = pos_x_q + C_ONE;
      end
      DIR_LEFT: begin
        if (pos_x_q == '0) out_of_bounds = 1'b1;
        else               next_x = pos_x_q - C_ONE;
      end
      default: begin
        if (pos_y_q == C_MAX) out_of_bounds = 1'b1;
        else                  next_y = pos_y_q + C_ONE;
      end
    endcase
  end

`ifdef REVISIT_CHECK_EN
  logic visited;

  visit_map #(
    .COORD_W (COORD_W)
  ) u_visit_map (
    .clk        (clk),
    .rst        (rst),
    .clear      (state_q == LOAD),
    .clear_addr ({SY, SX}),
    .mark       (accept),
    .mark_addr  ({next_y, next_x}),
    .test_addr  ({next_y, next_x}),
    .visited    (visited)
  );

  assign revisit = visited & ~out_of_bounds;
`else
  assign revisit = 1'b0;
`endif

  // Once error is set the walker is frozen: no further direction is even evaluated.
  assign try_move = (state_q == WALK) && dir_valid && !error_q;
  assign accept   = try_move && !out_of_bounds && !revisit;
  assign reject   = try_move && (out_of_bounds || revisit);

  always_comb begin
    state_d      = state_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    step_d       = step_q;
    move_valid_d = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    at_goal_d    = at_goal_q;
    error_d      = error_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD;
          pos_x_d   = SX;
          pos_y_d   = SY;
          step_d    = '0;
          at_goal_d = 1'b0;
          error_d   = 1'b0;
          busy_d    = 1'b1;
        end
      end
      LOAD: begin
        state_d = WALK;
      end
      WALK: begin
        if (accept) begin
          pos_x_d      = next_x;
          pos_y_d      = next_y;
          step_d       = (step_q == S_MAX) ? step_q : step_q + S_ONE;
          move_valid_d = 1'b1;
        end
        if (reject) begin
          error_d = 1'b1;
        end
        // A move arriving with stream_done is folded in before the goal test.
        if (stream_done) begin
          state_d   = FINISH;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          at_goal_d = (pos_x_d == GX) && (pos_y_d == GY) && !error_d;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      pos_x_q      <= SX;
      pos_y_q      <= SY;
      step_q       <= '0;
      move_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      at_goal_q    <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      step_q       <= step_d;
      move_valid_q <= move_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      at_goal_q    <= at_goal_d;
      error_q      <= error_d;
    end
  end

  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign step_count = step_q;
  assign move_valid = move_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign at_goal    = at_goal_q;
  assign error      = error_q;

endmodule

// File: tb/tb_path_walker.sv
// Directed bench for path_walker: a cell-level walk model checked every cycle, plus literal checks.
module tb_path_walker;

  localparam int N    = 16;
  localparam int SMAX = 255;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic dir_valid = 1'b0;
  logic [1:0] dir_in = 2'b00;
  logic stream_done = 1'b0;

  logic [3:0] a_x, a_y, b_x, b_y;
  logic [7:0] a_steps, b_steps;
  logic a_mv, a_busy, a_done, a_goal, a_err;
  logic b_mv, b_busy, b_done, b_goal, b_err;

  always #5 clk = ~clk;

  path_walker u_dut (
    .clk(clk), .rst(rst), .start(start), .dir_valid(dir_valid), .dir_in(dir_in),
    .stream_done(stream_done), .pos_x(a_x), .pos_y(a_y), .step_count(a_steps),
    .move_valid(a_mv), .busy(a_busy), .done(a_done), .at_goal(a_goal), .error(a_err)
  );

  path_walker #(.GOAL_X(1), .GOAL_Y(0)) u_dut_g10 (
    .clk(clk), .rst(rst), .start(start), .dir_valid(dir_valid), .dir_in(dir_in),
    .stream_done(stream_done), .pos_x(b_x), .pos_y(b_y), .step_count(b_steps),
    .move_valid(b_mv), .busy(b_busy), .done(b_done), .at_goal(b_goal), .error(b_err)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Walk model: phase 0 idle, 1 load, 2 walking, 3 finishing; cells as plain integers.
  int m_phase = 0;
  int m_x = 0, m_y = 0, m_steps = 0;
  bit m_mv = 0, m_busy = 0, m_done = 0, m_goal_a = 0, m_goal_b = 0, m_err = 0;
  bit m_seen [N*N];
  bit m_live = 0;

  always @(posedge clk) begin
    int nx, ny;
    bit bad;
    if (!rst) begin
      m_phase = 0; m_x = 0; m_y = 0; m_steps = 0;
      m_mv = 0; m_busy = 0; m_done = 0; m_goal_a = 0; m_goal_b = 0; m_err = 0;
      m_live = 1;
    end else begin
      m_mv = 0;
      m_done = 0;
      if (m_phase == 0) begin
        if (start) begin
          m_phase = 1; m_x = 0; m_y = 0; m_steps = 0;
          m_goal_a = 0; m_goal_b = 0; m_err = 0; m_busy = 1;
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
        foreach (m_seen[i]) m_seen[i] = 0;
        m_seen[0] = 1;
      end else if (m_phase == 2) begin
        if (dir_valid && !m_err) begin
          nx = m_x + ((dir_in == 2'b01) ? 1 : (dir_in == 2'b10) ? -1 : 0);
          ny = m_y + ((dir_in == 2'b11) ? 1 : (dir_in == 2'b00) ? -1 : 0);
          bad = (nx < 0) || (nx >= N) || (ny < 0) || (ny >= N);
`ifdef REVISIT_CHECK_EN
          if (!bad && m_seen[ny*N + nx]) bad = 1;
`endif
          if (bad) m_err = 1;
          else begin
            m_x = nx; m_y = ny; m_mv = 1;
            m_seen[ny*N + nx] = 1;
            if (m_steps < SMAX) m_steps++;
          end
        end
        if (stream_done) begin
          m_phase = 3; m_done = 1; m_busy = 0;
          m_goal_a = !m_err && m_x == 15 && m_y == 15;
          m_goal_b = !m_err && m_x == 1 && m_y == 0;
        end
      end else begin
        m_phase = 0;
      end
    end
  end

  int mv_cnt = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (m_live) begin
      chk("pos_x", a_x, m_x);
      chk("pos_y", a_y, m_y);
      chk("step_count", a_steps, m_steps);
      chk("move_valid", a_mv, m_mv);
      chk("busy", a_busy, m_busy);
      chk("done", a_done, m_done);
      chk("at_goal", a_goal, m_goal_a);
      chk("error", a_err, m_err);
      chk("g10_pos_x", b_x, m_x);
      chk("g10_pos_y", b_y, m_y);
      chk("g10_done", b_done, m_done);
      chk("g10_at_goal", b_goal, m_goal_b);
      if (a_mv === 1'b1) mv_cnt++;
      if (a_done === 1'b1) done_cnt++;
    end
  end

  task automatic drive(input logic s, input logic dv, input logic [1:0] d, input logic sd);
    @(negedge clk);
    start = s; dir_valid = dv; dir_in = d; stream_done = sd;
  endtask

  task automatic mv(input logic [1:0] d);
    drive(1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic begin_walk();
    drive(1'b1, 1'b1, 2'b01, 1'b0);  // dir alongside start is dropped
    drive(1'b0, 1'b1, 2'b01, 1'b0);  // dir during LOAD is dropped
  endtask

  task automatic end_walk();
    drive(1'b0, 1'b0, 2'b00, 1'b1);
    drive(1'b0, 1'b0, 2'b00, 1'b0);
    drive(1'b0, 1'b0, 2'b00, 1'b0);
  endtask

  initial begin
    int mv0, dn0;
    // 1: reset
    rst = 1'b0;
    drive(0, 0, 2'b00, 0);
    drive(0, 0, 2'b00, 0);
    chk("t1_pos", {a_x, a_y}, 0);
    chk("t1_flags", {a_busy, a_done, a_mv, a_goal, a_err}, 0);
    rst = 1'b1;
    drive(0, 0, 2'b00, 0);

    // 2: R,R,D,D with a stray start mid-walk
    mv0 = mv_cnt; dn0 = done_cnt;
    begin_walk();
    mv(2'b01);
    drive(1'b1, 1'b1, 2'b01, 1'b0);
    mv(2'b11);
    mv(2'b11);
    end_walk();
    chk("t2_pos", {a_x, a_y}, {4'd2, 4'd2});
    chk("t2_steps", a_steps, 4);
    chk("t2_moves", mv_cnt - mv0, 4);
    chk("t2_done", done_cnt - dn0, 1);
    chk("t2_flags", {a_goal, a_err, a_busy}, 0);

    // 3: single R together with stream_done; second instance has goal (1,0)
    begin_walk();
    drive(1'b0, 1'b1, 2'b01, 1'b1);
    drive(0, 0, 2'b00, 0);
    drive(0, 0, 2'b00, 0);
    chk("t3_pos", {b_x, b_y}, {4'd1, 4'd0});
    chk("t3_steps", b_steps, 1);
    chk("t3_goal", {b_goal, a_goal}, 2'b10);

    // 4: up from top row, then R must be ignored
    dn0 = done_cnt;
    begin_walk();
    mv(2'b00);
    mv(2'b01);
    end_walk();
    chk("t4_err", a_err, 1);
    chk("t4_pos", {a_x, a_y, a_steps}, 0);
    chk("t4_done", done_cnt - dn0, 1);
    chk("t4_goal", {a_goal, b_goal}, 0);

    // 5: reset mid-walk, then a clean walk
    dn0 = done_cnt;
    begin_walk();
    mv(2'b01);
    mv(2'b01);
    rst = 1'b0;
    drive(0, 0, 2'b00, 0);
    rst = 1'b1;
    drive(0, 0, 2'b00, 0);
    chk("t5_abort", {a_x, a_y, a_busy, a_done}, 0);
    chk("t5_nodone", done_cnt - dn0, 0);
    begin_walk();
    mv(2'b11);
    end_walk();
    chk("t5_again", {a_x, a_y, a_steps}, {4'd0, 4'd1, 8'd1});

    // 6: R then L (revisit of start cell)
    begin_walk();
    mv(2'b01);
    mv(2'b10);
    end_walk();
`ifdef REVISIT_CHECK_EN
    chk("t6_revisit", {a_x, a_y, a_steps, 7'd0, a_err}, {4'd1, 4'd0, 8'd1, 7'd0, 1'b1});
`else
    chk("t6_revisit", {a_x, a_y, a_steps, 7'd0, a_err}, {4'd0, 4'd0, 8'd2, 7'd0, 1'b0});
`endif

    // 7: corner to corner reaches the default goal
    begin_walk();
    for (int i = 0; i < 15; i++) mv(2'b01);
    for (int i = 0; i < 15; i++) mv(2'b11);
    end_walk();
    chk("t7_goal", {a_x, a_y, a_steps, 7'd0, a_goal}, {4'd15, 4'd15, 8'd30, 7'd0, 1'b1});

    // 8: stepping off the right edge
    begin_walk();
    for (int i = 0; i < 16; i++) mv(2'b01);
    end_walk();
    chk("t8_edge", {a_x, a_y, a_steps, 7'd0, a_err}, {4'd15, 4'd0, 8'd15, 7'd0, 1'b1});

`ifndef REVISIT_CHECK_EN
    // 9: step counter saturation
    begin_walk();
    for (int i = 0; i < 130; i++) begin
      mv(2'b01);
      mv(2'b10);
    end
    end_walk();
    chk("t9_sat", {a_steps, 7'd0, a_err}, {8'd255, 7'd0, 1'b0});
`endif

    drive(0, 0, 2'b00, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
